serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then sequences a single instance of the existing fulladder cell over WIDTH cycles, LSB first, with a registered carry. It returns sum, carry-out and signed overflow over a second valid/ready handshake, and serves as the area-minimal adder option next to the combinational adders in basic/.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/fulladder.sv | 13 +
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - state encoding and width limits shared by the serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

  // Bit counter must still be one bit wide when only a single bit is processed.
  function automatic int sa_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - one-bit full adder cell used as the serial datapath
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one fulladder sequenced LSB first over WIDTH cycles
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH:0]   w_sum_cat;

  fulladder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_last    = (r_cnt == LAST_BIT);
  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_sum_cat = {w_s, r_sum};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_sum   <= w_sum_cat[WIDTH:1];
          r_carry <= w_co;
          if (w_last) begin
            // r_carry here is the carry into the MSB; w_co is the carry out of it.
            r_cout <= w_co;
            r_ovf  <= r_carry ^ w_co;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed vectors and model-checked random runs for serial_add_ctrl
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        iv8, or8, cin8, ir8, ov8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv1, or1, cin1, ir1, ov1, co1, of1;
  logic [0:0]  a1, b1, s1;
  logic        iv13, or13, cin13, ir13, ov13, co13, of13;
  logic [12:0] a13, b13, s13;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1));
  serial_add_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13), .cin(cin13),
    .out_valid(ov13), .out_ready(or13), .sum(s13), .cout(co13), .ovf(of13));

  localparam int K8 = 0, K1 = 1, K13 = 2;
  int widths [3] = '{8, 1, 13};

  logic        ir_v [3];
  logic        ov_v [3];
  logic        co_v [3];
  logic        of_v [3];
  logic [31:0] s_v  [3];

  always_comb begin
    ir_v[0] = ir8;  ov_v[0] = ov8;  co_v[0] = co8;  of_v[0] = of8;  s_v[0] = 32'(s8);
    ir_v[1] = ir1;  ov_v[1] = ov1;  co_v[1] = co1;  of_v[1] = of1;  s_v[1] = 32'(s1);
    ir_v[2] = ir13; ov_v[2] = ov13; co_v[2] = co13; of_v[2] = of13; s_v[2] = 32'(s13);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
    case (k)
      K8:      begin iv8 = v;  a8 = a[7:0];   b8 = b[7:0];   cin8 = c;  end
      K1:      begin iv1 = v;  a1 = a[0:0];   b1 = b[0:0];   cin1 = c;  end
      default: begin iv13 = v; a13 = a[12:0]; b13 = b[12:0]; cin13 = c; end
    endcase
  endtask

  task automatic drive_ordy(input int k, input logic r);
    case (k)
      K8:      or8 = r;
      K1:      or1 = r;
      default: or13 = r;
    endcase
  endtask

  // Full handshake; lat counts clock edges after the accept edge until out_valid is seen.
  task automatic run_add(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input int hold, output logic [31:0] s, output logic co, output logic ov,
                         output int lat);
    int n;
    n = 0;
    drive_in(k, 1'b1, a, b, c);
    while (!ir_v[k] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("wait_in_ready", 64'(ir_v[k]), 64'd1);
    step();
    drive_in(k, 1'b0, ~a, ~b, ~c);
    lat = 0;
    while (!ov_v[k] && lat < 100) begin
      step();
      lat++;
    end
    repeat (hold) step();
    s  = s_v[k];
    co = co_v[k];
    ov = of_v[k];
    drive_ordy(k, 1'b1);
    step();
    drive_ordy(k, 1'b0);
  endtask

  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(c);
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {s, co, ov};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec [9];
    logic [31:0] s;
    logic        co, ov, stable, seen;
    int          lat, n;

    vec[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vec[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vec[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vec[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vec[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vec[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vec[8] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_in(k, 1'b0, 32'd0, 32'd0, 1'b0);
      drive_ordy(k, 1'b0);
    end
    repeat (3) step();
    chk("reset_in_ready", 64'(ir8), 64'd1);
    chk("reset_out_valid", 64'(ov8), 64'd0);
    chk("reset_result", 64'({s8, co8, of8}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_add(K8, 32'(vec[i].a), 32'(vec[i].b), vec[i].cin, 0, s, co, ov, lat);
      chk($sformatf("vec%0d_result", i), 64'({s[7:0], co, ov}),
          64'({vec[i].sum, vec[i].cout, vec[i].ovf}));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
    end

    // Backpressure: 0x55 + 0x33 = 0x88, positive + positive gives negative -> overflow.
    drive_in(K8, 1'b1, 32'h55, 32'h33, 1'b0);
    step();
    drive_in(K8, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (!ov8 && n < 100) begin
      step();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd8);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(ov8 && !ir8 && s8 == 8'h88 && !co8 && of8)) stable = 1'b0;
      step();
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    chk("bp_result", 64'({s8, co8, of8}), 64'({8'h88, 1'b0, 1'b1}));
    drive_ordy(K8, 1'b1);
    step();
    drive_ordy(K8, 1'b0);
    chk("bp_release_in_ready", 64'(ir8), 64'd1);
    chk("bp_release_out_valid", 64'(ov8), 64'd0);

    // in_valid pulsed with other operands mid-RUN must be ignored.
    drive_in(K8, 1'b1, 32'h12, 32'h34, 1'b0);
    step();
    drive_in(K8, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    drive_in(K8, 1'b1, 32'hAA, 32'h55, 1'b1);
    step();
    drive_in(K8, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (!ov8 && n < 100) begin
      step();
      n++;
    end
    chk("ign_result", 64'({s8, co8}), 64'({8'h46, 1'b0}));
    drive_ordy(K8, 1'b1);
    step();
    drive_ordy(K8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov8) seen = 1'b1;
      step();
    end
    chk("ign_no_second_result", 64'(seen), 64'd0);

    // Asynchronous reset in the fourth RUN cycle discards the operation.
    drive_in(K8, 1'b1, 32'h0F, 32'h01, 1'b0);
    step();
    drive_in(K8, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(ir8), 64'd1);
    chk("rst_mid_out_valid", 64'(ov8), 64'd0);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov8) seen = 1'b1;
      step();
    end
    chk("rst_no_result", 64'(seen), 64'd0);
    run_add(K8, 32'h01, 32'h01, 1'b0, 0, s, co, ov, lat);
    chk("rst_after_result", 64'({s[7:0], co, ov}), 64'({8'h02, 1'b0, 1'b0}));

    // Single-bit build.
    run_add(K1, 32'h1, 32'h1, 1'b1, 0, s, co, ov, lat);
    chk("w1_result", 64'({s[0], co, ov}), 64'(3'b110));
    chk("w1_latency", 64'(lat), 64'd1);
    run_add(K1, 32'h1, 32'h0, 1'b0, 2, s, co, ov, lat);
    chk("w1_result_b", 64'({s[0], co, ov}), 64'(3'b100));

    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 3; k += 2) begin
        logic [31:0] ra, rb;
        logic        rc;
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) step();
        run_add(k, ra, rb, rc, int'($urandom_range(0, 3)), s, co, ov, lat);
        chk($sformatf("rand_w%0d_t%0d_a%0h_b%0h_c%0d", widths[k], t, ra, rb, rc),
            64'({s, co, ov, 32'(lat)}), 64'({model(widths[k], ra, rb, rc), 32'(widths[k])}));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
